wb_decode_bus: RTL
==================

# wb_decode_bus

Registered, parametrised WISHBONE address decoder and response multiplexer: the next generation of the ATRI single-master bus. It sits between the one bus master (USB/I2C bridge) and NUM_SLAVES register slaves. The slave address map comes from parameter vectors rather than hard-coded compares. Requests and responses are registered, and the block adds a bus-timeout watchdog, a selectable unmapped-address response, and timeout statistics.

## Interface
Parameters:
- NUM_SLAVES, 9: number of slave ports (1..32).
- AW, 16: address width.
- DW, 8: data width.
- SLAVE_BASE, 0: NUM_SLAVES*AW-bit vector; slice i is slave i's base address.
- SLAVE_MASK, 0: NUM_SLAVES*AW-bit vector; slice i has 1s on the offset bits of slave i.
- TIMEOUT_CYCLES, 255: ACTIVE cycles without a slave response before the watchdog fires (2..65535).
- UNMAPPED_ERR, 0: 0 = unmapped access gets ack with all-ones data; 1 = unmapped access gets err.

Ports:
- clk_i  in  1  bus clock
- rst_n_i  in  1  synchronous reset, active low
- m_cyc_i, m_stb_i, m_we_i  in  1 each  master cycle/strobe/write
- m_adr_i  in  AW  master address
- m_dat_i  in  DW  master write data
- m_dat_o  out  DW  read data to master
- m_ack_o, m_err_o, m_rty_o  out  1 each  master response
- s_cyc_o, s_stb_o  out  NUM_SLAVES  per-slave cycle/strobe, one-hot
- s_we_o  out  1  shared write enable
- s_adr_o  out  AW  shared offset address (m_adr_i AND SLAVE_MASK of the selected slave)
- s_dat_o  out  DW  shared write data
- s_dat_i  in  NUM_SLAVES*DW  slave read data; slice i belongs to slave i
- s_ack_i, s_err_i, s_rty_i  in  NUM_SLAVES  slave responses
- timeout_cnt_o  out  8  saturating watchdog-event count
- timeout_slave_o  out  5  index of the slave that last timed out

## Operation
- Decode: slave i hits when (m_adr_i & ~MASK_i) == (BASE_i & ~MASK_i). On overlapping hits the lowest index wins. No hit means unmapped.
- States:
  - IDLE: outputs quiet. On m_cyc_i & m_stb_i:
    - hit: register sel (one-hot), s_adr_o, s_we_o and s_dat_o; go to ACTIVE.
    - unmapped: go to RESP with ack/data 0xFF..F (UNMAPPED_ERR=0) or err (UNMAPPED_ERR=1).
  - ACTIVE: s_cyc_o[sel] and s_stb_o[sel] are asserted, and the watchdog counter increments each cycle.
    - On s_ack_i[sel], s_err_i[sel] or s_rty_i[sel]: capture that response and s_dat_i[sel]; go to RESP. Priority on simultaneous responses is err > rty > ack.
    - Responses from non-selected slaves are ignored.
  - RESP: exactly one m_*_o response is high for one cycle, s_stb_o and s_cyc_o are low, and m_dat_o holds the captured data; then go to IDLE.
- m_cyc_i dropping in ACTIVE aborts: next state is IDLE, slave strobes drop the following edge, and no master response is given.
- The master must deassert m_stb_i in the cycle after it sees a response. A strobe still high in IDLE starts a new access.
- m_dat_o holds its last value outside RESP.

## Timing
- Reset (rst_n_i=0 at an edge):
  - state goes to IDLE.
  - All s_*_o, m_ack_o, m_err_o, m_rty_o, timeout_cnt_o and timeout_slave_o go to 0.
  - m_dat_o goes to 0.
  - Reset mid-transaction drops everything the same edge, with no response.
- Mapped access latency: master strobe sampled at edge 0 → slave strobe high after edge 0. A slave response sampled at edge k → master response high after edge k for exactly one cycle.
- A zero-wait slave (ack in its first strobe cycle) gives master ack 2 cycles after the master strobe.
- Unmapped access: master response 1 cycle after the master strobe.
- The watchdog counter clears on entry to ACTIVE.

## Configuration
- WB_BUS_TIMEOUT_EN defined:
  - If the watchdog reaches TIMEOUT_CYCLES in ACTIVE with no response, the state goes to RESP with m_err_o and data all-ones.
  - timeout_cnt_o increments and saturates at 255.
  - timeout_slave_o takes the encoded value of sel.
- WB_BUS_TIMEOUT_EN undefined: no watchdog is built, ACTIVE waits indefinitely, and timeout_cnt_o and timeout_slave_o are tied to 0.

## Test plan
- Default map with slave 2 at base 0x20, mask 0x1F: read 0x2A, slave 2 acks 1 cycle later with 0x5C → s_adr_o=0x0A, m_ack_o with m_dat_o=0x5C, 3 cycles after the strobe.
- Overlap test with slave 0 and slave 1 both mapping 0x00-0x0F: access 0x05 → only s_stb_o[0] asserted.
- Unmapped address 0xF000:
  - UNMAPPED_ERR=0 → m_ack_o with 0xFF one cycle later.
  - UNMAPPED_ERR=1 → m_err_o one cycle later.
- With WB_BUS_TIMEOUT_EN and TIMEOUT_CYCLES=4, a slave that never acks → m_err_o after 4 ACTIVE cycles, timeout_cnt_o=1, timeout_slave_o=selected index.
  - Repeat 300 times → timeout_cnt_o=255.
- Simultaneous s_ack_i and s_err_i from the selected slave → m_err_o only.
- Abort and reset:
  - Drop m_cyc_i in ACTIVE → slave strobe low next cycle, no master response.
  - rst_n_i=0 mid-ACTIVE → all outputs 0 after that edge.

Source files
------------

// File: rtl/wb_decode_bus.sv
`default_nettype none
// ============================================================================
// Module   : wb_decode_bus
// Function : registered WISHBONE address decoder / response mux with an
//            optional bus watchdog enabled by the WB_BUS_TIMEOUT_EN macro
// Revision : 1.0
// ============================================================================
module wb_decode_bus #(
  parameter int                       NUM_SLAVES     = 9,
  parameter int                       AW             = 16,
  parameter int                       DW             = 8,
  parameter logic [NUM_SLAVES*AW-1:0] SLAVE_BASE     = '0,
  parameter logic [NUM_SLAVES*AW-1:0] SLAVE_MASK     = '0,
  parameter int                       TIMEOUT_CYCLES = 255,
  parameter bit                       UNMAPPED_ERR   = 1'b0
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     m_cyc_i,
  input  logic                     m_stb_i,
  input  logic                     m_we_i,
  input  logic [AW-1:0]            m_adr_i,
  input  logic [DW-1:0]            m_dat_i,
  output logic [DW-1:0]            m_dat_o,
  output logic                     m_ack_o,
  output logic                     m_err_o,
  output logic                     m_rty_o,
  output logic [NUM_SLAVES-1:0]    s_cyc_o,
  output logic [NUM_SLAVES-1:0]    s_stb_o,
  output logic                     s_we_o,
  output logic [AW-1:0]            s_adr_o,
  output logic [DW-1:0]            s_dat_o,
  input  logic [NUM_SLAVES*DW-1:0] s_dat_i,
  input  logic [NUM_SLAVES-1:0]    s_ack_i,
  input  logic [NUM_SLAVES-1:0]    s_err_i,
  input  logic [NUM_SLAVES-1:0]    s_rty_i,
  output logic [7:0]               timeout_cnt_o,
  output logic [4:0]               timeout_slave_o
);

  localparam logic [15:0] c_TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [NUM_SLAVES-1:0] sel_q, sel_d;
  logic [4:0]            sel_idx_q, sel_idx_d;
  logic [AW-1:0]         adr_q, adr_d;
  logic                  we_q, we_d;
  logic [DW-1:0]         wdat_q, wdat_d;
  logic [DW-1:0]         rdat_q, rdat_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic                  rty_q, rty_d;
  logic [15:0]           wd_q, wd_d;
  logic [7:0]            tcnt_q, tcnt_d;
  logic [4:0]            tslv_q, tslv_d;

  logic [NUM_SLAVES-1:0] w_hit;
  logic [NUM_SLAVES-1:0] w_sel_oh;
  logic [4:0]            w_sel_idx;
  logic [AW-1:0]         w_off_mask;
  logic [DW-1:0]         w_rsp_dat;
  logic                  w_ack, w_err, w_rty;
  logic                  w_wd_fire;

  generate
    for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_dec
      assign w_hit[g] = ((m_adr_i & ~SLAVE_MASK[g*AW +: AW]) ==
                         (SLAVE_BASE[g*AW +: AW] & ~SLAVE_MASK[g*AW +: AW]));
    end
  endgenerate

  // Isolate the lowest set hit bit so overlapping windows resolve to the lowest index.
  assign w_sel_oh = w_hit & (~w_hit + NUM_SLAVES'(1));

  always_comb begin
    w_sel_idx  = '0;
    w_off_mask = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (w_sel_oh[i]) begin
        w_sel_idx  = 5'(i);
        w_off_mask = SLAVE_MASK[i*AW +: AW];
      end
    end
  end

  always_comb begin
    w_rsp_dat = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q[i]) begin
        w_rsp_dat = w_rsp_dat | s_dat_i[i*DW +: DW];
      end
    end
  end

  assign w_ack = |(s_ack_i & sel_q);
  assign w_err = |(s_err_i & sel_q);
  assign w_rty = |(s_rty_i & sel_q);

`ifdef WB_BUS_TIMEOUT_EN
  assign w_wd_fire = (state_q == ST_ACTIVE) && (wd_q == c_TO_LAST);
`else
  assign w_wd_fire = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    sel_idx_d = sel_idx_q;
    adr_d     = adr_q;
    we_d      = we_q;
    wdat_d    = wdat_q;
    rdat_d    = rdat_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    rty_d     = 1'b0;
    wd_d      = wd_q;
    tcnt_d    = tcnt_q;
    tslv_d    = tslv_q;
    case (state_q)
      ST_IDLE: begin
        if (m_cyc_i && m_stb_i) begin
          if (|w_hit) begin
            state_d   = ST_ACTIVE;
            sel_d     = w_sel_oh;
            sel_idx_d = w_sel_idx;
            adr_d     = m_adr_i & w_off_mask;
            we_d      = m_we_i;
            wdat_d    = m_dat_i;
            wd_d      = '0;
          end else begin
            state_d = ST_RESP;
            rdat_d  = '1;
            if (UNMAPPED_ERR) err_d = 1'b1;
            else              ack_d = 1'b1;
          end
        end
      end
      ST_ACTIVE: begin
        if (!m_cyc_i) begin
          state_d = ST_IDLE;
        end else if (w_err || w_rty || w_ack) begin
          state_d = ST_RESP;
          rdat_d  = w_rsp_dat;
          if (w_err)      err_d = 1'b1;
          else if (w_rty) rty_d = 1'b1;
          else            ack_d = 1'b1;
        end else if (w_wd_fire) begin
          state_d = ST_RESP;
          err_d   = 1'b1;
          rdat_d  = '1;
          tslv_d  = sel_idx_q;
          if (tcnt_q != 8'hFF) tcnt_d = tcnt_q + 8'd1;
        end else if (wd_q != c_TO_LAST) begin
          wd_d = wd_q + 16'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      sel_idx_q <= '0;
      adr_q     <= '0;
      we_q      <= 1'b0;
      wdat_q    <= '0;
      rdat_q    <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      rty_q     <= 1'b0;
      wd_q      <= '0;
      tcnt_q    <= '0;
      tslv_q    <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      sel_idx_q <= sel_idx_d;
      adr_q     <= adr_d;
      we_q      <= we_d;
      wdat_q    <= wdat_d;
      rdat_q    <= rdat_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      rty_q     <= rty_d;
      wd_q      <= wd_d;
      tcnt_q    <= tcnt_d;
      tslv_q    <= tslv_d;
    end
  end

  assign s_cyc_o         = (state_q == ST_ACTIVE) ? sel_q : '0;
  assign s_stb_o         = (state_q == ST_ACTIVE) ? sel_q : '0;
  assign s_we_o          = we_q;
  assign s_adr_o         = adr_q;
  assign s_dat_o         = wdat_q;
  assign m_dat_o         = rdat_q;
  assign m_ack_o         = ack_q;
  assign m_err_o         = err_q;
  assign m_rty_o         = rty_q;
  assign timeout_cnt_o   = tcnt_q;
  assign timeout_slave_o = tslv_q;

endmodule
`default_nettype wire
